// File: rtl/mips32_mem_responder.sv
// Shared instruction/data memory responder for a MIPS32 pipeline: one 1024x32 array,
// round-robin arbitration between fetch and data ports, fixed-latency one-cycle acknowledge.
module mips32_mem_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_r;
  state_t        state_n;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_n;
  port_t         grant_r;
  port_t         grant_s;
  port_t         last_grant_r;
  logic          contest_s;
  logic          accept_s;
  logic          access_s;
  logic [AW-1:0] addr_r;
  logic          we_r;
  logic [31:0]   wdata_r;
  logic [31:0]   mem [DEPTH];

  // Arbitration: last_grant only moves on contested grants, so conflicts alternate.
  always_comb begin
    contest_s = if_req && d_req;
    if (contest_s) begin
      grant_s = (last_grant_r == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (d_req) begin
      grant_s = PORT_DATA;
    end else begin
      grant_s = PORT_FETCH;
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req || d_req) begin
          accept_s = 1'b1;
          cnt_n    = CNT_INIT;
          state_n  = BUSY;
        end else begin
          state_n  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_n  = RESP;
        end else begin
          cnt_n    = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control registers; acks and busy are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      grant_r      <= PORT_FETCH;
      last_grant_r <= PORT_FETCH;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (accept_s) begin
        grant_r <= grant_s;
      end
      if (accept_s && contest_s) begin
        last_grant_r <= grant_s;
      end
      if_ack <= (state_n == RESP) && (grant_r == PORT_FETCH);
      d_ack  <= (state_n == RESP) && (grant_r == PORT_DATA);
      busy   <= (state_n != IDLE);
    end
  end

  // Request fields are captured at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      addr_r  <= (grant_s == PORT_DATA) ? d_addr : if_addr;
      we_r    <= (grant_s == PORT_DATA) && d_we;
      wdata_r <= d_wdata;
    end
  end

  // Storage write; reset blocks any store whose access edge has not yet happened.
  always_ff @(posedge clk) begin
    if (!rst && access_s && we_r) begin
      mem[addr_r] <= wdata_r;
    end
  end

  // Read data: only the granted port's register is updated, stores return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else if (access_s) begin
      if (grant_r == PORT_DATA) begin
        d_rdata <= we_r ? 32'd0 : mem[addr_r];
      end else begin
        if_rdata <= mem[addr_r];
      end
    end
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder: LAT=2 and LAT=1 instances, scoreboard queue
// of expected acknowledges filled when requests are driven and drained by a monitor.
module tb_mips32_mem_responder;

  typedef struct packed {
    logic        fetch;
    logic        dc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;

  logic        a_if_ack, a_d_ack, a_busy, b_if_ack, b_d_ack, b_busy;
  logic [31:0] a_if_rdata, a_d_rdata, b_if_rdata, b_d_rdata;
  logic        o_if_ack, o_d_ack, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mon_obs;
  logic [31:0] mmem [2][1024];
  bit          mvalid [2][1024];
  bit          m_last_fetch [2];
  logic [31:0] m_if [2];
  bit          m_if_ok [2];
  logic [31:0] m_d [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips32_mem_responder #(.LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req & ~sel), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .d_req(d_req & ~sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata), .busy(a_busy)
  );

  mips32_mem_responder #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req & sel), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(d_req & sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .busy(b_busy)
  );

  assign o_if_ack   = sel ? b_if_ack   : a_if_ack;
  assign o_d_ack    = sel ? b_d_ack    : a_d_ack;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_if_rdata = sel ? b_if_rdata : a_if_rdata;
  assign o_d_rdata  = sel ? b_d_rdata  : a_d_rdata;

  // Scoreboard monitor: every ack pops the oldest expectation and checks port and data.
  always @(negedge clk) begin
    if (o_if_ack || o_d_ack) begin
      checks++;
      assert (q.size() > 0 && !(o_if_ack && o_d_ack)) else begin
        failures++;
        $error("FAIL ack_expected: if_ack=%0b d_ack=%0b queued=%0d required one ack with a queued entry",
               o_if_ack, o_d_ack, q.size());
      end
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        assert (o_if_ack === mon_e.fetch) else begin
          failures++;
          $error("FAIL ack_port: if_ack=%0b required fetch=%0b", o_if_ack, mon_e.fetch);
        end
        if (!mon_e.dc) begin
          mon_obs = mon_e.fetch ? o_if_rdata : o_d_rdata;
          checks++;
          assert (mon_obs === mon_e.data) else begin
            failures++;
            $error("FAIL rdata: got %h required %h (fetch=%0b)", mon_obs, mon_e.data, mon_e.fetch);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic fetch, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.fetch = fetch;
    e.dc    = 1'b0;
    e.data  = 32'd0;
    if (fetch) begin
      if (mvalid[sel][addr]) begin
        e.data        = mmem[sel][addr];
        m_if[sel]     = e.data;
        m_if_ok[sel]  = 1'b1;
      end else begin
        e.dc          = 1'b1;
        m_if_ok[sel]  = 1'b0;
      end
    end else if (we) begin
      mmem[sel][addr]   = wdata;
      mvalid[sel][addr] = 1'b1;
      m_d[sel]          = 32'd0;
    end else begin
      e.data   = mmem[sel][addr];
      m_d[sel] = e.data;
    end
    q.push_back(e);
  endtask

  // Called just after a rising edge with the selected DUT idle; returns at the same phase.
  task automatic serve(input logic fr, input logic [9:0] fa, input logic dr, input logic dwe,
                       input logic [9:0] da, input logic [31:0] dwd);
    int   lat, n, acks, want;
    logic ff, got_f, got_d;
    lat  = (sel == 1'b1) ? 1 : 2;
    want = int'(fr) + int'(dr);
    ff   = (fr && dr) ? !m_last_fetch[sel] : fr;
    if (fr && dr) m_last_fetch[sel] = ff;
    if (ff) begin
      push_exp(1'b1, 1'b0, fa, 32'd0);
      if (dr) push_exp(1'b0, dwe, da, dwd);
    end else begin
      push_exp(1'b0, dwe, da, dwd);
      if (fr) push_exp(1'b1, 1'b0, fa, 32'd0);
    end
    if_req = fr; if_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    n = 0;
    acks = 0;
    while (acks < want && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        checks++;
        assert (o_busy === 1'b1) else begin
          failures++;
          $error("FAIL busy_after_accept: busy=%0b required 1", o_busy);
        end
      end
      if (o_if_ack || o_d_ack) begin
        acks++;
        got_f = o_if_ack;
        got_d = o_d_ack;
        checks++;
        assert (n == ((acks == 1) ? lat + 2 : 2 * lat + 4)) else begin
          failures++;
          $error("FAIL ack_latency: ack %0d at negedge %0d required %0d", acks, n,
                 (acks == 1) ? lat + 2 : 2 * lat + 4);
        end
        @(posedge clk);
        #1;
        if (got_f) if_req = 1'b0;
        if (got_d) d_req = 1'b0;
      end
    end
    checks++;
    assert (acks == want) else begin
      failures++;
      $error("FAIL ack_timeout: got %0d acks required %0d", acks, want);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    checks++;
    assert ({o_if_ack, o_d_ack, o_busy} === 3'b000) else begin
      failures++;
      $error("FAIL ack_pulse: if_ack/d_ack/busy=%b required 000", {o_if_ack, o_d_ack, o_busy});
    end
    @(posedge clk);
    #1;
    checks++;
    assert (o_d_rdata === m_d[sel]) else begin
      failures++;
      $error("FAIL d_rdata_hold: got %h required %h", o_d_rdata, m_d[sel]);
    end
    if (m_if_ok[sel]) begin
      checks++;
      assert (o_if_rdata === m_if[sel]) else begin
        failures++;
        $error("FAIL if_rdata_hold: got %h required %h", o_if_rdata, m_if[sel]);
      end
    end
  endtask

  initial begin
    int n, prev;
    m_last_fetch[0] = 1'b1; m_last_fetch[1] = 1'b1;
    m_if[0] = 32'd0; m_if[1] = 32'd0; m_if_ok[0] = 1'b1; m_if_ok[1] = 1'b1;
    m_d[0] = 32'd0; m_d[1] = 32'd0;
    rst = 1'b1; sel = 1'b0;
    if_req = 1'b1; if_addr = 10'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 10'd0; d_wdata = 32'd0;

    // reset held three cycles with a fetch pending
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      assert ({o_if_ack, o_d_ack, o_busy, o_if_rdata, o_d_rdata} === 67'd0) else begin
        failures++;
        $error("FAIL reset_outputs: got %h required 0",
               {o_if_ack, o_d_ack, o_busy, o_if_rdata, o_d_rdata});
      end
    end
    rst = 1'b0;
    serve(1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);

    // preload through the data port
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd0, 32'h28010005);
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd1, 32'h24020007);
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd2, 32'h00221820);
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd9, 32'h11111111);
    serve(1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);

    // store then load, fetch data must not move
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    serve(1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0);

    // two conflicts: data first, then fetch first
    serve(1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0);
    serve(1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0);

    // back-to-back fetches with req held
    push_exp(1'b1, 1'b0, 10'd0, 32'd0);
    push_exp(1'b1, 1'b0, 10'd1, 32'd0);
    push_exp(1'b1, 1'b0, 10'd2, 32'd0);
    if_req = 1'b1; if_addr = 10'd0; prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!o_if_ack && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      assert (o_if_ack === 1'b1) else begin
        failures++;
        $error("FAIL b2b_timeout: fetch %0d if_ack=%0b required 1", k, o_if_ack);
      end
      if (k > 0) begin
        checks++;
        assert (cyc - prev == 4) else begin
          failures++;
          $error("FAIL b2b_spacing: fetch %0d spacing %0d required 4", k, cyc - prev);
        end
      end
      prev = cyc;
      @(posedge clk);
      #1;
      if (k < 2) if_addr = 10'(k + 1);
      else if_req = 1'b0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;

    // reset one cycle before a store's access edge
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    assert ({o_if_ack, o_d_ack, o_busy, o_if_rdata, o_d_rdata} === 67'd0) else begin
      failures++;
      $error("FAIL midreset_outputs: got %h required 0",
             {o_if_ack, o_d_ack, o_busy, o_if_rdata, o_d_rdata});
    end
    @(posedge clk);
    #1;
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    m_if[0] = 32'd0; m_if_ok[0] = 1'b1; m_d[0] = 32'd0; m_last_fetch[0] = 1'b1;
    m_if[1] = 32'd0; m_if_ok[1] = 1'b1; m_d[1] = 32'd0; m_last_fetch[1] = 1'b1;
    @(negedge clk);
    checks++;
    assert ({o_if_ack, o_d_ack} === 2'b00) else begin
      failures++;
      $error("FAIL midreset_noack: acks=%b required 00", {o_if_ack, o_d_ack});
    end
    @(posedge clk);
    #1;
    serve(1'b0, 10'd0, 1'b1, 1'b0, 10'd9, 32'd0);

    // LAT=1 instance, top address and aliasing against address 0
    sel = 1'b1;
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd1023, 32'hA5A55A5A);
    serve(1'b0, 10'd0, 1'b1, 1'b1, 10'd0, 32'h0BADF00D);
    serve(1'b0, 10'd0, 1'b1, 1'b0, 10'd1023, 32'd0);
    serve(1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    serve(1'b1, 10'd1023, 1'b0, 1'b0, 10'd0, 32'd0);
    serve(1'b1, 10'd0, 1'b1, 1'b0, 10'd1023, 32'd0);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: %0d entries left required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
